// File: rtl/datamem_bus_pkg.sv
// ---------------------------------------------------------------------------
// datamem_bus_pkg
// Shared definitions for the data-memory bus bridge:
//   - address-region base bytes (addr[31:24])
//   - timer register offsets (addr[23:0]) and their word-index forms
//   - access-width encodings for memSignWidth[1:0]
//   - bus FSM state type
//   - lane helpers: write replication, byte-lane mask, lane merge,
//     load extraction with sign/zero extension, alignment check
// ---------------------------------------------------------------------------
package datamem_bus_pkg;

    localparam logic [7:0] REGION_GPIO  = 8'h10;
    localparam logic [7:0] REGION_TIMER = 8'h20;
    localparam logic [7:0] REGION_FB    = 8'h21;
    localparam logic [7:0] REGION_SDRAM = 8'h80;

    localparam logic [23:0] TMR_CMP_LO   = 24'h00_4000;
    localparam logic [23:0] TMR_CMP_HI   = 24'h00_4004;
    localparam logic [23:0] TMR_MTIME_LO = 24'h00_BFF8;
    localparam logic [23:0] TMR_MTIME_HI = 24'h00_BFFC;

    // Word indices (offset[23:2]) used by the timer register decoder
    localparam logic [21:0] TMR_CMP_LO_W   = TMR_CMP_LO[23:2];
    localparam logic [21:0] TMR_CMP_HI_W   = TMR_CMP_HI[23:2];
    localparam logic [21:0] TMR_MTIME_LO_W = TMR_MTIME_LO[23:2];
    localparam logic [21:0] TMR_MTIME_HI_W = TMR_MTIME_HI[23:2];

    localparam logic [1:0] WIDTH_BYTE = 2'b00;
    localparam logic [1:0] WIDTH_HALF = 2'b01;
    localparam logic [1:0] WIDTH_WORD = 2'b10;

    typedef enum logic [2:0] {
        ST_INIT = 3'd0,
        ST_IDLE = 3'd1,
        ST_WAIT = 3'd2,
        ST_DONE = 3'd3,
        ST_HOLD = 3'd4
    } state_e;

    // True for the four decoded regions; everything else faults.
    function automatic logic is_mapped(input logic [7:0] region);
        case (region)
            REGION_GPIO, REGION_TIMER, REGION_FB, REGION_SDRAM: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Width encoding 2'b11 has no meaning and is rejected with the misaligned cases.
    function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] off);
        case (width)
            WIDTH_BYTE: return 1'b0;
            WIDTH_HALF: return off[0];
            WIDTH_WORD: return (off != 2'b00);
            default:    return 1'b1;
        endcase
    endfunction

    // Store data is LSB-aligned; replicating it covers whichever lane the address selects.
    function automatic logic [31:0] lane_replicate(input logic [31:0] d, input logic [1:0] width);
        case (width)
            WIDTH_BYTE: return {4{d[7:0]}};
            WIDTH_HALF: return {2{d[15:0]}};
            default:    return d;
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] width, input logic [1:0] off);
        case (width)
            WIDTH_BYTE: return 4'b0001 << off;
            WIDTH_HALF: return off[1] ? 4'b1100 : 4'b0011;
            WIDTH_WORD: return 4'b1111;
            default:    return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] mask);
        logic [31:0] res;
        res = old_w;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_w[8*i +: 8];
            end
        end
        return res;
    endfunction

    // width[2]=1 selects zero extension, otherwise the lane MSB is replicated.
    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [2:0] width,
                                                input logic [1:0] off);
        logic [31:0] sh;
        logic        sx_byte;
        logic        sx_half;
        sh      = word >> {off, 3'b000};
        sx_byte = sh[7] & ~width[2];
        sx_half = sh[15] & ~width[2];
        case (width[1:0])
            WIDTH_BYTE: return {{24{sx_byte}}, sh[7:0]};
            WIDTH_HALF: return {{16{sx_half}}, sh[15:0]};
            WIDTH_WORD: return word;
            default:    return 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/datamem_bus_clint.sv
// ---------------------------------------------------------------------------
// clint_timer
// Machine timer: free-running 64-bit mtime advanced every TICK_DIV clocks,
// 64-bit mtimecmp (R/W, resets to all-ones) and registered mtip compare.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   word_sel      timer offset addr[23:2]
//   wr_en         one-cycle register write strobe
//   wr_mask       byte-lane enables for the write
//   wr_data       lane-replicated write data
//   rd_data       selected register word (0 for unused offsets)
//   mtip          registered (mtime >= mtimecmp), unsigned
// ---------------------------------------------------------------------------
module clint_timer
    import datamem_bus_pkg::*;
#(
    parameter int TICK_DIV = 25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [21:0] word_sel,
    input  logic        wr_en,
    input  logic [3:0]  wr_mask,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        mtip
);

    localparam logic [31:0] TICK_LAST = 32'(TICK_DIV - 1);

    logic [31:0] pre_q, pre_d;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] cmp_q, cmp_d;
    logic        mtip_q, mtip_d;

    // Prescaler, mtime advance, mtimecmp writes and compare.
    always_comb begin
        if (pre_q == TICK_LAST) begin
            pre_d   = 32'd0;
            mtime_d = mtime_q + 64'd1;
        end else begin
            pre_d   = pre_q + 32'd1;
            mtime_d = mtime_q;
        end

        cmp_d = cmp_q;
        if (wr_en) begin
            case (word_sel)
                TMR_CMP_LO_W: cmp_d[31:0]  = lane_merge(cmp_q[31:0], wr_data, wr_mask);
                TMR_CMP_HI_W: cmp_d[63:32] = lane_merge(cmp_q[63:32], wr_data, wr_mask);
                default:      cmp_d        = cmp_q;
            endcase
        end else begin
            cmp_d = cmp_q;
        end

        mtip_d = (mtime_q >= cmp_q);
    end

    // Register read mux; mtime is read-only, unused offsets read as zero.
    always_comb begin
        case (word_sel)
            TMR_CMP_LO_W:   rd_data = cmp_q[31:0];
            TMR_CMP_HI_W:   rd_data = cmp_q[63:32];
            TMR_MTIME_LO_W: rd_data = mtime_q[31:0];
            TMR_MTIME_HI_W: rd_data = mtime_q[63:32];
            default:        rd_data = 32'd0;
        endcase
    end

    // Timer state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q   <= 32'd0;
            mtime_q <= 64'd0;
            cmp_q   <= {64{1'b1}};
            mtip_q  <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            mtime_q <= mtime_d;
            cmp_q   <= cmp_d;
            mtip_q  <= mtip_d;
        end
    end

    assign mtip = mtip_q;

endmodule

// File: rtl/datamem_bus.sv
// ---------------------------------------------------------------------------
// datamem_bus
// Bridges a held load/store request onto GPIO, machine timer, framebuffer
// and SDRAM, returning a registered, lane-extracted load result with a
// one-cycle opFinish pulse (qualified by fault).
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   memRead/memWrite              held request until opFinish
//   memSignWidth, addr, data      width/extension, byte address, store data
//   dataOut, opFinish, fault      registered completion outputs
//   initFinish                    sticky once the SDRAM controller is ready
//   sdram_*                       SDRAM controller command interface
//   fb_*                          framebuffer port (fixed read latency)
//   io_gpio                       GPIO output register
//   csr_mtip                      machine timer interrupt pending
// ---------------------------------------------------------------------------
module datamem_bus
    import datamem_bus_pkg::*;
#(
    parameter int GPIO_W        = 8,
    parameter int TICK_DIV      = 25,
    parameter int SDRAM_TIMEOUT = 1024,
    parameter int FB_RD_LAT     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic [2:0]        memSignWidth,
    input  logic [31:0]       addr,
    input  logic [31:0]       data,
    output logic [31:0]       dataOut,
    output logic              opFinish,
    output logic              fault,
    output logic              initFinish,
    output logic              sdram_enable,
    output logic              sdram_write,
    output logic [23:0]       sdram_addr,
    output logic [31:0]       sdram_wdata,
    output logic [1:0]        sdram_dwidth,
    input  logic [31:0]       sdram_rdata,
    input  logic              sdram_ready,
    output logic              fb_re,
    output logic              fb_we,
    output logic [15:0]       fb_addr,
    output logic [3:0]        fb_mask,
    output logic [31:0]       fb_wdata,
    input  logic [31:0]       fb_rdata,
    output logic [GPIO_W-1:0] io_gpio,
    output logic              csr_mtip
);

    localparam logic [31:0] FB_LAT_C     = 32'(FB_RD_LAT);
    localparam logic [31:0] TIMEOUT_LAST = 32'(SDRAM_TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic [2:0]        width_q, width_d;
    logic              write_q, write_d;
    logic [GPIO_W-1:0] gpio_q, gpio_d;
    logic [31:0]       data_out_q, data_out_d;
    logic              op_finish_q, op_finish_d;
    logic              fault_q, fault_d;
    logic              init_finish_q, init_finish_d;
    logic              sdram_enable_q, sdram_enable_d;
    logic              fb_re_q, fb_re_d;
    logic              fb_we_q, fb_we_d;

    logic              req_s;
    logic              req_illegal_s;
    logic              timer_we_s;
    logic [31:0]       timer_rdata_s;
    logic [31:0]       wdata_rep_s;
    logic [3:0]        mask_s;

    assign req_s         = memRead | memWrite;
    assign req_illegal_s = (memRead & memWrite)
                         | is_misaligned(memSignWidth[1:0], addr[1:0])
                         | ~is_mapped(addr[31:24]);
    assign wdata_rep_s   = lane_replicate(data_q, width_q[1:0]);
    assign mask_s        = lane_mask(width_q[1:0], addr_q[1:0]);

    clint_timer #(
        .TICK_DIV (TICK_DIV)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .word_sel (addr_q[23:2]),
        .wr_en    (timer_we_s),
        .wr_mask  (mask_s),
        .wr_data  (wdata_rep_s),
        .rd_data  (timer_rdata_s),
        .mtip     (csr_mtip)
    );

    // Bus FSM next-state, strobe and completion logic.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        addr_d         = addr_q;
        data_d         = data_q;
        width_d        = width_q;
        write_d        = write_q;
        gpio_d         = gpio_q;
        data_out_d     = data_out_q;
        op_finish_d    = 1'b0;
        fault_d        = 1'b0;
        init_finish_d  = init_finish_q;
        sdram_enable_d = 1'b0;
        fb_re_d        = 1'b0;
        fb_we_d        = 1'b0;
        timer_we_s     = 1'b0;

        case (state_q)
            ST_INIT: begin
                if (sdram_ready) begin
                    state_d       = ST_IDLE;
                    init_finish_d = 1'b1;
                end else begin
                    state_d = ST_INIT;
                end
            end

            ST_IDLE: begin
                if (req_s) begin
                    // Capture the request so the downstream ports stay stable for the whole access.
                    addr_d  = addr;
                    data_d  = data;
                    width_d = memSignWidth;
                    write_d = memWrite;
                    cnt_d   = 32'd0;
                    if (req_illegal_s) begin
                        state_d     = ST_DONE;
                        op_finish_d = 1'b1;
                        fault_d     = 1'b1;
                        data_out_d  = 32'd0;
                    end else begin
                        state_d        = ST_WAIT;
                        sdram_enable_d = (addr[31:24] == REGION_SDRAM);
                        fb_re_d        = (addr[31:24] == REGION_FB) & memRead;
                        fb_we_d        = (addr[31:24] == REGION_FB) & memWrite;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_WAIT: begin
                cnt_d = cnt_q + 32'd1;
                case (addr_q[31:24])
                    REGION_GPIO: begin
                        state_d     = ST_DONE;
                        op_finish_d = 1'b1;
                        if (write_q) begin
                            gpio_d     = data_q[GPIO_W-1:0];
                            data_out_d = 32'd0;
                        end else begin
                            data_out_d = load_extract(32'(gpio_q), width_q, addr_q[1:0]);
                        end
                    end
                    REGION_TIMER: begin
                        state_d     = ST_DONE;
                        op_finish_d = 1'b1;
                        timer_we_s  = write_q;
                        if (write_q) begin
                            data_out_d = 32'd0;
                        end else begin
                            data_out_d = load_extract(timer_rdata_s, width_q, addr_q[1:0]);
                        end
                    end
                    REGION_FB: begin
                        // cnt_q counts cycles since the strobe; fb_rdata is valid at FB_RD_LAT.
                        if (cnt_q == FB_LAT_C) begin
                            state_d     = ST_DONE;
                            op_finish_d = 1'b1;
                            if (write_q) begin
                                data_out_d = 32'd0;
                            end else begin
                                data_out_d = load_extract(fb_rdata, width_q, addr_q[1:0]);
                            end
                        end else begin
                            state_d = ST_WAIT;
                        end
                    end
                    REGION_SDRAM: begin
                        // Ready seen in the strobe cycle is the idle level, not completion.
                        if ((cnt_q != 32'd0) && sdram_ready) begin
                            state_d     = ST_DONE;
                            op_finish_d = 1'b1;
                            if (write_q) begin
                                data_out_d = 32'd0;
                            end else begin
                                data_out_d = load_extract(sdram_rdata, width_q, addr_q[1:0]);
                            end
                        end else if (cnt_q == TIMEOUT_LAST) begin
                            state_d     = ST_DONE;
                            op_finish_d = 1'b1;
                            fault_d     = 1'b1;
                            data_out_d  = 32'd0;
                        end else begin
                            state_d = ST_WAIT;
                        end
                    end
                    default: begin
                        state_d     = ST_DONE;
                        op_finish_d = 1'b1;
                        fault_d     = 1'b1;
                        data_out_d  = 32'd0;
                    end
                endcase
            end

            ST_DONE: begin
                state_d = ST_HOLD;
            end

            ST_HOLD: begin
                // Wait for the requester to drop so a held request is not reissued.
                if (req_s) begin
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Bus FSM and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_INIT;
            cnt_q          <= 32'd0;
            addr_q         <= 32'd0;
            data_q         <= 32'd0;
            width_q        <= 3'd0;
            write_q        <= 1'b0;
            gpio_q         <= '0;
            data_out_q     <= 32'd0;
            op_finish_q    <= 1'b0;
            fault_q        <= 1'b0;
            init_finish_q  <= 1'b0;
            sdram_enable_q <= 1'b0;
            fb_re_q        <= 1'b0;
            fb_we_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            addr_q         <= addr_d;
            data_q         <= data_d;
            width_q        <= width_d;
            write_q        <= write_d;
            gpio_q         <= gpio_d;
            data_out_q     <= data_out_d;
            op_finish_q    <= op_finish_d;
            fault_q        <= fault_d;
            init_finish_q  <= init_finish_d;
            sdram_enable_q <= sdram_enable_d;
            fb_re_q        <= fb_re_d;
            fb_we_q        <= fb_we_d;
        end
    end

    assign dataOut      = data_out_q;
    assign opFinish     = op_finish_q;
    assign fault        = fault_q;
    assign initFinish   = init_finish_q;
    assign sdram_enable = sdram_enable_q;
    assign sdram_write  = write_q;
    assign sdram_addr   = addr_q[23:0];
    assign sdram_wdata  = wdata_rep_s;
    assign sdram_dwidth = width_q[1:0];
    assign fb_re        = fb_re_q;
    assign fb_we        = fb_we_q;
    assign fb_addr      = addr_q[15:0];
    assign fb_mask      = mask_s;
    assign fb_wdata     = wdata_rep_s;
    assign io_gpio      = gpio_q;

endmodule

// File: tb/tb_datamem_bus.sv
// ---------------------------------------------------------------------------
// tb_datamem_bus
// Directed bench for datamem_bus with hand-computed expected values.
// DUT built with TICK_DIV=2, SDRAM_TIMEOUT=20, FB_RD_LAT=2, GPIO_W=8.
// ---------------------------------------------------------------------------
module tb_datamem_bus;

    logic        clk;
    logic        rst;
    logic        memRead, memWrite;
    logic [2:0]  memSignWidth;
    logic [31:0] addr, data;
    logic [31:0] dataOut;
    logic        opFinish, fault, initFinish;
    logic        sdram_enable, sdram_write;
    logic [23:0] sdram_addr;
    logic [31:0] sdram_wdata;
    logic [1:0]  sdram_dwidth;
    logic [31:0] sdram_rdata;
    logic        sdram_ready;
    logic        fb_re, fb_we;
    logic [15:0] fb_addr;
    logic [3:0]  fb_mask;
    logic [31:0] fb_wdata;
    logic [31:0] fb_rdata;
    logic [7:0]  io_gpio;
    logic        csr_mtip;

    int checks   = 0;
    int failures = 0;

    int          n_cyc, n_strobe, n_fbwe, n_fin;
    logic        fin;
    logic [31:0] r_data;
    logic        r_fault;
    logic [23:0] s_addr;
    logic [31:0] s_wdata, s_fbw;
    logic        s_write;
    logic [1:0]  s_dwidth;
    logic [3:0]  s_mask;
    logic [15:0] s_fbaddr;
    logic [31:0] edge_cnt;
    logic [31:0] e0;

    datamem_bus #(
        .GPIO_W        (8),
        .TICK_DIV      (2),
        .SDRAM_TIMEOUT (20),
        .FB_RD_LAT     (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .memRead      (memRead),
        .memWrite     (memWrite),
        .memSignWidth (memSignWidth),
        .addr         (addr),
        .data         (data),
        .dataOut      (dataOut),
        .opFinish     (opFinish),
        .fault        (fault),
        .initFinish   (initFinish),
        .sdram_enable (sdram_enable),
        .sdram_write  (sdram_write),
        .sdram_addr   (sdram_addr),
        .sdram_wdata  (sdram_wdata),
        .sdram_dwidth (sdram_dwidth),
        .sdram_rdata  (sdram_rdata),
        .sdram_ready  (sdram_ready),
        .fb_re        (fb_re),
        .fb_we        (fb_we),
        .fb_addr      (fb_addr),
        .fb_mask      (fb_mask),
        .fb_wdata     (fb_wdata),
        .fb_rdata     (fb_rdata),
        .io_gpio      (io_gpio),
        .csr_mtip     (csr_mtip)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edges since reset release; mtime model is edge_cnt/2.
    always @(posedge clk) begin
        if (rst) edge_cnt <= 32'd0;
        else     edge_cnt <= edge_cnt + 32'd1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one request, wait (bounded) for opFinish, then release and return to IDLE.
    task automatic access(input string tag, input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [2:0] w, input int max_cyc);
        memRead = rd; memWrite = wr; addr = a; data = d; memSignWidth = w;
        n_cyc = 0; n_strobe = 0; n_fbwe = 0; fin = 1'b0;
        r_data = 32'hDEAD_BEEF; r_fault = 1'bx;
        while (!fin && n_cyc < max_cyc) begin
            tick();
            n_cyc++;
            if (sdram_enable || fb_re || fb_we) begin
                n_strobe++;
                s_addr = sdram_addr; s_wdata = sdram_wdata; s_write = sdram_write;
                s_dwidth = sdram_dwidth; s_mask = fb_mask; s_fbaddr = fb_addr; s_fbw = fb_wdata;
            end
            if (fb_we) n_fbwe++;
            if (opFinish) begin
                fin = 1'b1; r_data = dataOut; r_fault = fault;
            end
        end
        check({tag, "_finished"}, 64'(fin), 64'd1);
        memRead = 1'b0; memWrite = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        rst = 1'b1; memRead = 1'b0; memWrite = 1'b0; memSignWidth = 3'b010;
        addr = 32'd0; data = 32'd0; sdram_rdata = 32'd0; sdram_ready = 1'b0;
        fb_rdata = 32'h1122_3344;
        tick(); tick();
        check("rst_opfinish", 64'(opFinish), 64'd0);
        check("rst_fault", 64'(fault), 64'd0);
        check("rst_initfinish", 64'(initFinish), 64'd0);
        check("rst_gpio", 64'(io_gpio), 64'd0);
        check("rst_dataout", 64'(dataOut), 64'd0);
        check("rst_mtip", 64'(csr_mtip), 64'd0);
        check("rst_strobes", 64'({sdram_enable, fb_re, fb_we}), 64'd0);

        // INIT waits for sdram_ready
        rst = 1'b0;
        tick(); tick();
        check("init_wait", 64'(initFinish), 64'd0);
        sdram_ready = 1'b1;
        tick();
        check("init_done", 64'(initFinish), 64'd1);

        // Timer: mtimecmp resets to all-ones, then program 10
        access("cmphi_rd", 1'b1, 1'b0, 32'h2000_4004, 32'd0, 3'b010, 10);
        check("cmphi_reset", 64'(r_data), 64'hFFFF_FFFF);
        check("cmphi_cyc", 64'(n_cyc), 64'd2);
        access("cmphi_wr", 1'b0, 1'b1, 32'h2000_4004, 32'd0, 3'b010, 10);
        access("cmplo_wr", 1'b0, 1'b1, 32'h2000_4000, 32'd10, 3'b010, 10);
        check("mtip_before", 64'(csr_mtip), 64'd0);
        n_cyc = 0;
        while (!csr_mtip && n_cyc < 100) begin
            tick();
            n_cyc++;
        end
        // mtime reaches 10 at edge 20; mtip registers one edge later
        check("mtip_rise_edge", 64'(edge_cnt), 64'd21);

        e0 = edge_cnt;
        access("mtime_rd", 1'b1, 1'b0, 32'h2000_BFF8, 32'd0, 3'b010, 10);
        check("mtime_lo", 64'(r_data), 64'((e0 + 32'd1) / 32'd2));
        access("mtimehi_rd", 1'b1, 1'b0, 32'h2000_BFFC, 32'd0, 3'b010, 10);
        check("mtime_hi", 64'(r_data), 64'd0);
        access("cmplo_rd", 1'b1, 1'b0, 32'h2000_4000, 32'd0, 3'b010, 10);
        check("cmplo_val", 64'(r_data), 64'd10);
        access("tmr_unused_wr", 1'b0, 1'b1, 32'h2000_0100, 32'h1234_5678, 3'b010, 10);
        check("tmr_unused_wr_fault", 64'(r_fault), 64'd0);
        access("tmr_unused_rd", 1'b1, 1'b0, 32'h2000_0100, 32'd0, 3'b010, 10);
        check("tmr_unused_rd_val", 64'(r_data), 64'd0);

        // GPIO write held for 10 cycles: exactly one completion
        memWrite = 1'b1; addr = 32'h1000_0000; data = 32'h0000_00A5; memSignWidth = 3'b000;
        n_fin = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (opFinish) n_fin++;
        end
        check("gpio_hold_val", 64'(io_gpio), 64'hA5);
        check("gpio_hold_once", 64'(n_fin), 64'd1);
        memWrite = 1'b0;
        tick(); tick();
        access("gpio_rd_w", 1'b1, 1'b0, 32'h1000_0000, 32'd0, 3'b010, 10);
        check("gpio_rd_word", 64'(r_data), 64'h0000_00A5);
        access("gpio_rd_b", 1'b1, 1'b0, 32'h1000_0000, 32'd0, 3'b000, 10);
        check("gpio_rd_sbyte", 64'(r_data), 64'hFFFF_FFA5);

        // SDRAM loads with ready held high: completion two cycles after the strobe
        sdram_rdata = 32'h80FF_0000;
        access("sd_b3", 1'b1, 1'b0, 32'h8000_0003, 32'd0, 3'b000, 50);
        check("sd_b3_data", 64'(r_data), 64'hFFFF_FF80);
        check("sd_b3_fault", 64'(r_fault), 64'd0);
        check("sd_b3_cyc", 64'(n_cyc), 64'd3);
        check("sd_b3_strobes", 64'(n_strobe), 64'd1);
        check("sd_b3_addr", 64'(s_addr), 64'h00_0003);
        check("sd_b3_write", 64'(s_write), 64'd0);
        access("sd_b2z", 1'b1, 1'b0, 32'h8000_0002, 32'd0, 3'b100, 50);
        check("sd_b2z_data", 64'(r_data), 64'h0000_00FF);
        access("sd_h2", 1'b1, 1'b0, 32'h8000_0002, 32'd0, 3'b001, 50);
        check("sd_h2_data", 64'(r_data), 64'hFFFF_80FF);
        access("sd_w0", 1'b1, 1'b0, 32'h8000_0000, 32'd0, 3'b010, 50);
        check("sd_w0_data", 64'(r_data), 64'h80FF_0000);
        access("sd_wr", 1'b0, 1'b1, 32'h8000_0001, 32'h0000_0012, 3'b000, 50);
        check("sd_wr_wdata", 64'(s_wdata), 64'h1212_1212);
        check("sd_wr_write", 64'(s_write), 64'd1);
        check("sd_wr_dwidth", 64'(s_dwidth), 64'd0);
        check("sd_wr_fault", 64'(r_fault), 64'd0);

        // Illegal accesses: straight to DONE, no strobe
        access("sd_mis_h", 1'b1, 1'b0, 32'h8000_0001, 32'd0, 3'b001, 10);
        check("sd_mis_h_fault", 64'(r_fault), 64'd1);
        check("sd_mis_h_strobes", 64'(n_strobe), 64'd0);
        check("sd_mis_h_cyc", 64'(n_cyc), 64'd1);
        check("sd_mis_h_data", 64'(r_data), 64'd0);
        access("both", 1'b1, 1'b1, 32'h1000_0000, 32'h0000_0011, 3'b010, 10);
        check("both_fault", 64'(r_fault), 64'd1);
        check("both_gpio_kept", 64'(io_gpio), 64'hA5);
        access("unmapped", 1'b1, 1'b0, 32'h4000_0000, 32'd0, 3'b010, 10);
        check("unmapped_fault", 64'(r_fault), 64'd1);
        check("unmapped_strobes", 64'(n_strobe), 64'd0);
        access("mis_w", 1'b0, 1'b1, 32'h1000_0002, 32'h0000_0022, 3'b010, 10);
        check("mis_w_fault", 64'(r_fault), 64'd1);
        check("mis_w_gpio_kept", 64'(io_gpio), 64'hA5);

        // SDRAM timeout with ready held low: opFinish 20 cycles after the strobe
        sdram_ready = 1'b0;
        access("sd_to", 1'b1, 1'b0, 32'h8000_0000, 32'd0, 3'b010, 100);
        check("sd_to_fault", 64'(r_fault), 64'd1);
        check("sd_to_cyc", 64'(n_cyc), 64'd21);
        check("sd_to_data", 64'(r_data), 64'd0);
        sdram_ready = 1'b1;

        // Framebuffer with two-cycle read latency
        access("fb_rw", 1'b1, 1'b0, 32'h2100_0010, 32'd0, 3'b010, 20);
        check("fb_rw_data", 64'(r_data), 64'h1122_3344);
        check("fb_rw_cyc", 64'(n_cyc), 64'd4);
        check("fb_rw_addr", 64'(s_fbaddr), 64'h0010);
        check("fb_rw_mask", 64'(s_mask), 64'hF);
        access("fb_rb", 1'b1, 1'b0, 32'h2100_0001, 32'd0, 3'b100, 20);
        check("fb_rb_data", 64'(r_data), 64'h0000_0033);
        check("fb_rb_mask", 64'(s_mask), 64'h2);
        access("fb_wh", 1'b0, 1'b1, 32'h2100_0002, 32'h0000_BEEF, 3'b001, 20);
        check("fb_wh_we", 64'(n_fbwe), 64'd1);
        check("fb_wh_mask", 64'(s_mask), 64'hC);
        check("fb_wh_wdata", 64'(s_fbw), 64'hBEEF_BEEF);

        // Reset while in WAIT of an FB read
        memRead = 1'b1; addr = 32'h2100_0000; memSignWidth = 3'b010;
        tick();
        check("rstw_fbre_before", 64'(fb_re), 64'd1);
        rst = 1'b1;
        tick();
        check("rstw_fbre", 64'(fb_re), 64'd0);
        check("rstw_initfinish", 64'(initFinish), 64'd0);
        check("rstw_gpio", 64'(io_gpio), 64'd0);
        check("rstw_mtip", 64'(csr_mtip), 64'd0);
        check("rstw_dataout", 64'(dataOut), 64'd0);
        rst = 1'b0; sdram_ready = 1'b0;
        addr = 32'h1000_0000;
        n_fin = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (opFinish) n_fin++;
        end
        check("rstw_init_blocks", 64'(n_fin), 64'd0);
        memRead = 1'b0;
        sdram_ready = 1'b1;
        tick();
        check("rstw_reinit", 64'(initFinish), 64'd1);
        access("post_rst_gpio", 1'b1, 1'b0, 32'h1000_0000, 32'd0, 3'b010, 10);
        check("post_rst_gpio_val", 64'(r_data), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/datamem_bus.md
DATAMEM_BUS -- requirements
Module: datamem_bus

Interface
REQ-001 The block SHALL have a single clock and a synchronous, active-high reset, named clk and rst.
REQ-002 Parameter GPIO_W SHALL default to 8 and set the io_gpio width.
REQ-003 Parameter TICK_DIV SHALL default to 25 and set the clk cycles per mtime increment (>=1).
REQ-004 Parameter SDRAM_TIMEOUT SHALL default to 1024 and set the WAIT cycles allowed before fault.
REQ-005 Parameter FB_RD_LAT SHALL default to 1 and set the fb_rdata cycles after fb_re.
REQ-006 clk  in  1  clock.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 memRead  in  1  load request, held until opFinish.
REQ-009 memWrite  in  1  store request, held until opFinish.
REQ-010 memSignWidth  in  3  [1:0] 00 byte, 01 half, 10 word; [2] 1 = zero-extend.
REQ-011 addr  in  32  byte address.
REQ-012 data  in  32  store data, LSB-aligned.
REQ-013 dataOut  out  32  load result, registered, valid with opFinish.
REQ-014 opFinish  out  1  one-cycle completion pulse.
REQ-015 fault  out  1  qualifies opFinish: misaligned, unmapped, illegal or timed-out access.
REQ-016 initFinish  out  1  high once sdram_ready is first seen; sticky until rst.
REQ-017 sdram_enable  out  1  one-cycle command strobe.
REQ-018 sdram_write  out  1  write qualifier for sdram_enable.
REQ-019 sdram_addr  out  24  addr[23:0].
REQ-020 sdram_wdata  out  32  data replicated onto the lanes selected by addr[1:0].
REQ-021 sdram_dwidth  out  2  memSignWidth[1:0].
REQ-022 sdram_rdata  in  32  raw 32-bit word, valid when sdram_ready rises after a command.
REQ-023 sdram_ready  in  1  controller idle/done.
REQ-024 fb_re  out  1  one-cycle framebuffer read strobe.
REQ-025 fb_we  out  1  one-cycle framebuffer write strobe.
REQ-026 fb_addr  out  16  addr[15:0].
REQ-027 fb_mask  out  4  byte-lane enables derived from width and addr[1:0].
REQ-028 fb_wdata  out  32  same lane-replicated data as sdram_wdata.
REQ-029 fb_rdata  in  32  raw word, valid FB_RD_LAT cycles after fb_re.
REQ-030 io_gpio  out  GPIO_W  GPIO register at 0x1000_0000.
REQ-031 csr_mtip  out  1  registered (mtime >= mtimecmp), unsigned 64-bit compare.

Function
REQ-032 Decode SHALL use addr[31:24]: 0x10 GPIO, 0x20 timer, 0x21 framebuffer, 0x80 SDRAM; any other value faults.
REQ-033 FSM states SHALL be INIT, IDLE, WAIT, DONE, HOLD; INIT->IDLE when sdram_ready=1.
REQ-034 IDLE with exactly one of memRead/memWrite SHALL go to WAIT, issuing one strobe if the access is legal; if illegal it SHALL go to DONE with fault=1 and no strobe.
REQ-035 Both memRead and memWrite high, halfword with addr[0]=1, or word with addr[1:0]!=0 SHALL be illegal.
REQ-036 GPIO and timer accesses SHALL complete one cycle in WAIT; FB SHALL complete after FB_RD_LAT cycles; SDRAM SHALL complete on the first cycle of WAIT with sdram_ready=1 that is at least one cycle after sdram_enable.
REQ-037 WAIT reaching SDRAM_TIMEOUT cycles SHALL go to DONE with fault=1.
REQ-038 DONE SHALL assert opFinish for exactly one cycle; HOLD SHALL then stay until memRead|memWrite=0, so a held request never issues twice.
REQ-039 Loads SHALL select the lane by addr[1:0] and sign- or zero-extend per memSignWidth[2]; faulted loads return 0.
REQ-040 Timer registers SHALL be 0x20004000/4 mtimecmp lo/hi (R/W) and 0x2000BFF8/C mtime lo/hi (read-only); other timer offsets read 0, ignore writes, and do not fault.
REQ-041 mtime SHALL increment by 1 every TICK_DIV clocks regardless of FSM state and wrap modulo 2^64.
REQ-042 A GPIO write SHALL store data[GPIO_W-1:0]; a GPIO read SHALL return the register value.

Reset
REQ-043 Reset SHALL return the FSM to INIT and set all strobes, opFinish, fault, initFinish, io_gpio, mtime, dataOut and csr_mtip to 0 and mtimecmp to all-ones; reset mid-operation SHALL drop strobes on the next edge.

Structure
REQ-044 A shared package SHALL hold the region base bytes, timer offsets, width encodings and FSM state typedef.
REQ-045 The timer (mtime, prescaler, mtimecmp, compare) SHALL be a sub-module named clint_timer.

Verification
REQ-046 Byte load from 0x80000003 with sdram_rdata=0x80FF_0000, sign-extended -> dataOut=0xFFFF_FF80, fault=0.
REQ-047 Halfword load from 0x80000001 -> opFinish with fault=1 and no sdram_enable pulse.
REQ-048 Set TICK_DIV=2, write mtimecmp hi=0 and lo=10 after reset -> csr_mtip rises on the cycle after mtime reaches 10.
REQ-049 Hold memWrite to 0x10000000 with data=0xA5 for 10 cycles -> io_gpio=0xA5, exactly one opFinish, no reissue.
REQ-050 SDRAM read with sdram_ready held low -> opFinish and fault at cycle SDRAM_TIMEOUT.
REQ-051 Assert rst while in WAIT of an FB read -> strobes clear next edge, FSM returns to INIT, initFinish=0.
